// File: rtl/mod_exp_pkg.sv
// mod_exp_pkg: shared state encoding, default width and bit-length helper for the exponentiation engine
package mod_exp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_DEF = 32;
  function automatic int bit_len(input logic [63:0] v);
    bit_len = 0;
    for (int i = 0; i < 64; i++) if (v[i]) bit_len = i + 1;
  endfunction
endpackage

// File: rtl/mod_exp_engine_mod_mul.sv
// mod_mul: combinational double-width multiply reduced mod m, or truncated to WIDTH when m is 0
module mod_mul #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r,
  output logic             hi_nz
);
  logic [2*WIDTH-1:0] p;
  assign p     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign hi_nz = |p[2*WIDTH-1:WIDTH];
  assign r     = (m == '0) ? p[WIDTH-1:0] : WIDTH'(p % {{WIDTH{1'b0}}, m});
endmodule

// File: rtl/mod_exp_engine.sv
// mod_exp_engine: handshaked right-to-left square-and-multiply x^n (mod m), one exponent bit per cycle
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  state_t           state;
  logic [WIDTH-1:0] e, base, acc, m_r, acc_p, sq_p, e_nxt, acc_n;
  logic             acc_hi, sq_hi, ovf_s, ovf_n;
  mod_mul #(.WIDTH(WIDTH)) u_acc (.a(acc), .b(base), .m(m_r), .r(acc_p), .hi_nz(acc_hi));
  mod_mul #(.WIDTH(WIDTH)) u_sq (.a(base), .b(base), .m(m_r), .r(sq_p), .hi_nz(sq_hi));
  assign e_nxt = e >> 1;
  assign acc_n = e[0] ? acc_p : acc;
  // a final-iteration base square is never consumed, so it cannot flag overflow
  assign ovf_n = ovf_s | ((m_r == '0) & ((e[0] & acc_hi) | ((e_nxt != '0) & sq_hi)));
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      ovf_s  <= 1'b0;
      e      <= '0;
      base   <= '0;
      acc    <= '0;
      m_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            e     <= n;
            base  <= (m == '0) ? x : x % m;
            acc   <= (m == WIDTH'(1)) ? '0 : WIDTH'(1);
            m_r   <= m;
            ovf_s <= 1'b0;
            busy  <= 1'b1;
            if (n == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= (m == WIDTH'(1)) ? '0 : WIDTH'(1);
              ovf    <= 1'b0;
            end else state <= RUN;
          end
        end
        RUN: begin
          e     <= e_nxt;
          acc   <= acc_n;
          base  <= sq_p;
          ovf_s <= ovf_n;
          if (e_nxt == '0) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= acc_n;
            ovf    <= ovf_n;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
